// File: rtl/keypad_entry.sv
// Scans a 4x4 hex keypad, shifts accepted digits into DataOut, and turns Enter/Undo buttons into pulses.
// Key accept latency is 2 sync cycles plus (N_STABLE+1) scan slots plus 1; a button pulse follows its edge by 2+N_DEBOUNCER+1 cycles.
// There is no backpressure: pulses are fire-and-forget. `KEYPAD_CLEAR_ON_ENTER_EN makes Enter clear DataOut.
module keypad_entry #(
    parameter int N_SCAN      = 100000,
    parameter int N_STABLE    = 4,
    parameter int N_DEBOUNCER = 5000000
) (
    input  logic        clk,
    input  logic        resetN,
    input  logic [3:0]  Rows,
    input  logic        EnterBtn,
    input  logic        UndoBtn,
    output logic [3:0]  Cols,
    output logic [15:0] DataOut,
    output logic [3:0]  KeyCode,
    output logic        KeyValid,
    output logic        Enter,
    output logic        Undo
);

    localparam int SCAN_W = (N_SCAN > 1) ? $clog2(N_SCAN) : 1;
    localparam int STB_W  = $clog2(N_STABLE + 1);
    localparam int DB_W   = (N_DEBOUNCER > 1) ? $clog2(N_DEBOUNCER) : 1;

    localparam logic [1:0] S_SCAN     = 2'd0;
    localparam logic [1:0] S_DEBOUNCE = 2'd1;
    localparam logic [1:0] S_ACCEPT   = 2'd2;
    localparam logic [1:0] S_RELEASE  = 2'd3;

    logic [3:0]        rows_s1, rows_s2;
    logic [1:0]        btn_s1, btn_s2;
    logic [1:0]        state;
    logic [1:0]        col;
    logic [1:0]        key_row;
    logic [SCAN_W-1:0] slot_cnt;
    logic [STB_W-1:0]  stable_cnt;
    logic [DB_W-1:0]   db_cnt [2];
    logic [1:0]        db_level, db_level_d, btn_pulse;

    logic        slot_end;
    logic        row_valid;
    logic [1:0]  row_idx;
    logic [3:0]  code;
    logic        clr_data;
    logic [15:0] data_base;

    assign Cols     = ~(4'b0001 << col);
    assign slot_end = (slot_cnt == SCAN_W'(N_SCAN - 1));
    assign code     = {key_row, col};
    assign Enter    = btn_pulse[0];
    assign Undo     = btn_pulse[1];

`ifdef KEYPAD_CLEAR_ON_ENTER_EN
    assign clr_data = Enter;
`else
    assign clr_data = 1'b0;
`endif
    // Clear and accept in the same cycle leaves only the new digit.
    assign data_base = clr_data ? 16'h0000 : DataOut;

    // Zero or several low rows are treated as no key.
    always_comb begin
        row_valid = 1'b0;
        row_idx   = 2'd0;
        case (rows_s2)
            4'b1110: begin row_valid = 1'b1; row_idx = 2'd0; end
            4'b1101: begin row_valid = 1'b1; row_idx = 2'd1; end
            4'b1011: begin row_valid = 1'b1; row_idx = 2'd2; end
            4'b0111: begin row_valid = 1'b1; row_idx = 2'd3; end
            default: ;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!resetN) begin
            rows_s1 <= 4'hF;
            rows_s2 <= 4'hF;
            btn_s1  <= 2'b00;
            btn_s2  <= 2'b00;
        end else begin
            rows_s1 <= Rows;
            rows_s2 <= rows_s1;
            btn_s1  <= {UndoBtn, EnterBtn};
            btn_s2  <= btn_s1;
        end
    end

    always_ff @(posedge clk) begin
        if (!resetN) begin
            state      <= S_SCAN;
            col        <= 2'd0;
            key_row    <= 2'd0;
            slot_cnt   <= '0;
            stable_cnt <= '0;
            KeyValid   <= 1'b0;
            KeyCode    <= 4'h0;
            DataOut    <= 16'h0000;
        end else begin
            KeyValid <= 1'b0;
            slot_cnt <= slot_end ? '0 : slot_cnt + 1'b1;
            if (clr_data)
                DataOut <= 16'h0000;
            case (state)
                S_SCAN: begin
                    if (slot_end) begin
                        if (row_valid) begin
                            key_row    <= row_idx;
                            stable_cnt <= '0;
                            state      <= S_DEBOUNCE;
                        end else begin
                            col <= col + 2'd1;
                        end
                    end
                end
                S_DEBOUNCE: begin
                    if (slot_end) begin
                        if (row_valid && row_idx == key_row) begin
                            if (stable_cnt == STB_W'(N_STABLE - 1))
                                state <= S_ACCEPT;
                            else
                                stable_cnt <= stable_cnt + 1'b1;
                        end else begin
                            state <= S_SCAN;
                            col   <= col + 2'd1;
                        end
                    end
                end
                S_ACCEPT: begin
                    KeyValid   <= 1'b1;
                    KeyCode    <= code;
                    DataOut    <= {data_base[11:0], code};
                    stable_cnt <= '0;
                    state      <= S_RELEASE;
                end
                default: begin
                    // Column stays frozen so a held key is seen but never re-accepted.
                    if (slot_end) begin
                        if (row_valid) begin
                            stable_cnt <= '0;
                        end else if (stable_cnt == STB_W'(N_STABLE - 1)) begin
                            state <= S_SCAN;
                            col   <= col + 2'd1;
                        end else begin
                            stable_cnt <= stable_cnt + 1'b1;
                        end
                    end
                end
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (!resetN) begin
            for (int i = 0; i < 2; i++)
                db_cnt[i] <= '0;
            db_level   <= 2'b00;
            db_level_d <= 2'b00;
            btn_pulse  <= 2'b00;
        end else begin
            db_level_d <= db_level;
            btn_pulse  <= db_level & ~db_level_d;
            for (int i = 0; i < 2; i++) begin
                if (btn_s2[i] == db_level[i]) begin
                    db_cnt[i] <= '0;
                end else if (db_cnt[i] == DB_W'(N_DEBOUNCER - 1)) begin
                    db_level[i] <= btn_s2[i];
                    db_cnt[i]   <= '0;
                end else begin
                    db_cnt[i] <= db_cnt[i] + 1'b1;
                end
            end
        end
    end

endmodule

// File: tb/tb_keypad_entry.sv
// Bench for keypad_entry: a keypad matrix model drives Rows from Cols, and accepted keys are checked against a scoreboard.
module tb_keypad_entry;

    localparam int NS  = 4;
    localparam int NST = 2;
    localparam int ND  = 8;
    localparam int PRESS_LAT = 2 + (NST + 1) * NS + 1;
    localparam int BTN_LAT   = 2 + ND + 1;

    logic        clk = 1'b0;
    logic        resetN;
    logic [3:0]  Rows;
    logic        EnterBtn, UndoBtn;
    logic [3:0]  Cols;
    logic [15:0] DataOut;
    logic [3:0]  KeyCode;
    logic        KeyValid, Enter, Undo;

    logic [15:0] pressed = 16'h0;
    logic [3:0]  prev_rows = 4'hF;
    logic [15:0] mdl_data = 16'h0;
    logic [3:0]  kv_code [$];
    logic [15:0] kv_data [$];
    int          kv_lat [$];
    int tests = 0, fails = 0, cyc = 0, last_fall = 0;
    int en_cnt = 0, un_cnt = 0, en_cyc = -1, un_cyc = -1;

    keypad_entry #(.N_SCAN(NS), .N_STABLE(NST), .N_DEBOUNCER(ND)) dut (
        .clk(clk), .resetN(resetN), .Rows(Rows), .EnterBtn(EnterBtn), .UndoBtn(UndoBtn),
        .Cols(Cols), .DataOut(DataOut), .KeyCode(KeyCode), .KeyValid(KeyValid),
        .Enter(Enter), .Undo(Undo)
    );

    always #5 clk = ~clk;

    // A pressed key pulls its row low only while its column is driven low.
    always_comb begin
        Rows = 4'hF;
        for (int r = 0; r < 4; r++)
            for (int c = 0; c < 4; c++)
                if (pressed[4*r+c] && Cols[c] === 1'b0)
                    Rows[r] = 1'b0;
    end

    task automatic tick();
        @(negedge clk);
        cyc++;
        if (Rows != 4'hF && prev_rows == 4'hF)
            last_fall = cyc;
        prev_rows = Rows;
        if (KeyValid === 1'b1) begin
            kv_code.push_back(KeyCode);
            kv_data.push_back(DataOut);
            kv_lat.push_back(cyc - last_fall);
        end
        if (Enter === 1'b1) begin en_cnt++; en_cyc = cyc; end
        if (Undo === 1'b1)  begin un_cnt++; un_cyc = cyc; end
    endtask

    task automatic press_key(input logic [3:0] code, input int hold, input int rel);
        pressed = 16'h0;
        pressed[code] = 1'b1;
        repeat (hold) tick();
        pressed = 16'h0;
        repeat (rel) tick();
    endtask

    task automatic test_reset();
        resetN = 1'b0; EnterBtn = 1'b0; UndoBtn = 1'b0; pressed = 16'h0;
        repeat (3) tick();
        tests++; if (Cols !== 4'b1110) begin fails++; $display("FAIL reset_cols got %b want 1110", Cols); end
        tests++; if (DataOut !== 16'h0) begin fails++; $display("FAIL reset_data got %h want 0000", DataOut); end
        tests++; if (KeyCode !== 4'h0) begin fails++; $display("FAIL reset_keycode got %h want 0", KeyCode); end
        tests++; if ({KeyValid, Enter, Undo} !== 3'b000) begin fails++; $display("FAIL reset_pulses got %b want 000", {KeyValid, Enter, Undo}); end
        resetN = 1'b1;
        mdl_data = 16'h0;
    endtask

    task automatic test_four_digit();
        int base;
        logic [3:0]  codes [4];
        logic [15:0] exp_d [4];
        base = kv_code.size();
        codes[0] = 4'h6; codes[1] = 4'hF; codes[2] = 4'h0; codes[3] = 4'h9;
        for (int i = 0; i < 4; i++) begin
            press_key(codes[i], 40, 40);
            mdl_data = {mdl_data[11:0], codes[i]};
            exp_d[i] = mdl_data;
        end
        tests++;
        if (kv_code.size() - base !== 4) begin
            fails++; $display("FAIL four_digit_count got %0d want 4", kv_code.size() - base);
        end else begin
            for (int i = 0; i < 4; i++) begin
                tests++; if (kv_code[base+i] !== codes[i]) begin fails++; $display("FAIL four_digit_code[%0d] got %h want %h", i, kv_code[base+i], codes[i]); end
                tests++; if (kv_data[base+i] !== exp_d[i]) begin fails++; $display("FAIL four_digit_data[%0d] got %h want %h", i, kv_data[base+i], exp_d[i]); end
                tests++; if (kv_lat[base+i] > PRESS_LAT) begin fails++; $display("FAIL four_digit_latency[%0d] got %0d want <= %0d", i, kv_lat[base+i], PRESS_LAT); end
            end
        end
        tests++; if (DataOut !== 16'h6F09) begin fails++; $display("FAIL four_digit_final got %h want 6F09", DataOut); end
    endtask

    task automatic test_held_key();
        int base;
        base = kv_code.size();
        press_key(4'h1, 400, 40);
        mdl_data = {mdl_data[11:0], 4'h1};
        tests++;
        if (kv_code.size() - base !== 1) begin
            fails++; $display("FAIL held_count got %0d want 1", kv_code.size() - base);
        end else begin
            tests++; if (kv_code[base] !== 4'h1) begin fails++; $display("FAIL held_code got %h want 1", kv_code[base]); end
        end
        tests++; if (DataOut !== mdl_data) begin fails++; $display("FAIL held_data got %h want %h", DataOut, mdl_data); end
    endtask

    // The key flips every scan slot, so no two consecutive samples ever agree.
    task automatic test_bounce();
        int base;
        base = kv_code.size();
        pressed = 16'h0;
        for (int i = 0; i < 40; i++) begin
            pressed[8] = ~pressed[8];
            repeat (NS) tick();
        end
        pressed = 16'h0;
        repeat (40) tick();
        tests++; if (kv_code.size() !== base) begin fails++; $display("FAIL bounce_rejected got %0d pulses want 0", kv_code.size() - base); end
        tests++; if (DataOut !== mdl_data) begin fails++; $display("FAIL bounce_data got %h want %h", DataOut, mdl_data); end
    endtask

    task automatic test_multi_row();
        int base, c, r0, r1;
        base = kv_code.size();
        for (int k = 0; k < 3; k++) begin
            c  = $urandom_range(0, 3);
            r0 = $urandom_range(0, 3);
            r1 = (r0 + $urandom_range(1, 3)) % 4;
            pressed = 16'h0;
            pressed[4*r0+c] = 1'b1;
            pressed[4*r1+c] = 1'b1;
            repeat (100) tick();
            pressed = 16'h0;
            repeat (40) tick();
        end
        tests++; if (kv_code.size() !== base) begin fails++; $display("FAIL multi_row_rejected got %0d pulses want 0", kv_code.size() - base); end
    endtask

    task automatic test_random_entry();
        int base, n;
        logic [3:0]  exp_c [$];
        logic [15:0] exp_d [$];
        logic [3:0]  code;
        base = kv_code.size();
        n = 8;
        for (int i = 0; i < n; i++) begin
            code = 4'($urandom_range(0, 15));
            press_key(code, $urandom_range(40, 80), $urandom_range(30, 60));
            mdl_data = {mdl_data[11:0], code};
            exp_c.push_back(code);
            exp_d.push_back(mdl_data);
        end
        tests++;
        if (kv_code.size() - base !== n) begin
            fails++; $display("FAIL random_count got %0d want %0d", kv_code.size() - base, n);
        end else begin
            for (int i = 0; i < n; i++) begin
                tests++; if (kv_code[base+i] !== exp_c[i]) begin fails++; $display("FAIL random_code[%0d] got %h want %h", i, kv_code[base+i], exp_c[i]); end
                tests++; if (kv_data[base+i] !== exp_d[i]) begin fails++; $display("FAIL random_data[%0d] got %h want %h", i, kv_data[base+i], exp_d[i]); end
                tests++; if (kv_lat[base+i] > PRESS_LAT) begin fails++; $display("FAIL random_latency[%0d] got %0d want <= %0d", i, kv_lat[base+i], PRESS_LAT); end
            end
        end
    endtask

    task automatic test_reset_mid_press();
        int base;
        logic [3:0] code;
        code = 4'($urandom_range(0, 15));
        pressed = 16'h0;
        pressed[code] = 1'b1;
        repeat (8) tick();
        resetN = 1'b0;
        repeat (3) tick();
        resetN = 1'b1;
        base = kv_code.size();
        repeat (60) tick();
        pressed = 16'h0;
        repeat (40) tick();
        mdl_data = {12'h000, code};
        tests++;
        if (kv_code.size() - base !== 1) begin
            fails++; $display("FAIL midreset_count got %0d want 1", kv_code.size() - base);
        end else begin
            tests++; if (kv_code[base] !== code) begin fails++; $display("FAIL midreset_code got %h want %h", kv_code[base], code); end
        end
        tests++; if (DataOut !== mdl_data) begin fails++; $display("FAIL midreset_data got %h want %h", DataOut, mdl_data); end
    endtask

    task automatic test_enter();
        int e0, t0;
        logic [15:0] exp_after;
`ifdef KEYPAD_CLEAR_ON_ENTER_EN
        exp_after = 16'h0000;
`else
        exp_after = mdl_data;
`endif
        e0 = en_cnt;
        EnterBtn = 1'b1;
        repeat (5) tick();
        EnterBtn = 1'b0;
        repeat (20) tick();
        tests++; if (en_cnt !== e0) begin fails++; $display("FAIL enter_glitch got %0d pulses want 0", en_cnt - e0); end

        t0 = cyc;
        EnterBtn = 1'b1;
        for (int k = 0; k < 20; k++) begin
            tick();
            if (cyc == t0 + BTN_LAT + 1) begin
                tests++; if (DataOut !== exp_after) begin fails++; $display("FAIL enter_data got %h want %h", DataOut, exp_after); end
            end
        end
        EnterBtn = 1'b0;
        repeat (20) tick();
        tests++; if (en_cnt - e0 !== 1) begin fails++; $display("FAIL enter_count got %0d want 1", en_cnt - e0); end
        tests++; if (en_cyc - t0 !== BTN_LAT) begin fails++; $display("FAIL enter_latency got %0d want %0d", en_cyc - t0, BTN_LAT); end
        mdl_data = exp_after;
    endtask

    task automatic test_simultaneous();
        int e0, u0, t0;
        e0 = en_cnt; u0 = un_cnt; t0 = cyc;
        EnterBtn = 1'b1; UndoBtn = 1'b1;
        repeat (20) tick();
        EnterBtn = 1'b0; UndoBtn = 1'b0;
        repeat (20) tick();
        tests++; if (en_cnt - e0 !== 1) begin fails++; $display("FAIL simul_enter_count got %0d want 1", en_cnt - e0); end
        tests++; if (un_cnt - u0 !== 1) begin fails++; $display("FAIL simul_undo_count got %0d want 1", un_cnt - u0); end
        tests++; if (un_cyc - t0 !== BTN_LAT) begin fails++; $display("FAIL simul_undo_latency got %0d want %0d", un_cyc - t0, BTN_LAT); end
        tests++; if (en_cyc !== un_cyc) begin fails++; $display("FAIL simul_same_cycle got enter@%0d undo@%0d want equal", en_cyc, un_cyc); end
    endtask

    initial begin
        test_reset();
        test_four_digit();
        test_held_key();
        test_bounce();
        test_multi_row();
        test_random_entry();
        test_reset_mid_press();
        test_enter();
        test_simultaneous();
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
